// File: rtl/gb_video_pkg.sv
// Shared constants and types for the Game Boy triple-buffer video path.
package gb_video_pkg;

  localparam int unsigned FRAME_PIXELS = 23040;
  localparam int unsigned MIN_PIXELS   = 11600;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned SYNC_STAGES  = 2;
  localparam int unsigned CNT_W        = 8;

  typedef logic [1:0]       buf_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACTIVE,
    W_FULL
  } wr_state_t;

  // Saturating increment for the statistics counters.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Capture-side, RAM-side and display-side signals of the frame buffer scheduler.
interface frame_buffer_scheduler_if;
  import gb_video_pkg::*;

  logic              gb_de;
  logic              gb_vsync;
  logic              rd_vsync_n;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  buf_idx_t          wr_buf;
  buf_idx_t          rd_buf;
  logic              frame_fresh;
  cnt_t              drop_cnt;
  cnt_t              repeat_cnt;

  modport slave (
    input  gb_de, gb_vsync, rd_vsync_n,
    output wr_addr, wr_en, wr_buf, rd_buf, frame_fresh, drop_cnt, repeat_cnt
  );

  modport master (
    output gb_de, gb_vsync, rd_vsync_n,
    input  wr_addr, wr_en, wr_buf, rd_buf, frame_fresh, drop_cnt, repeat_cnt
  );

endinterface

// File: rtl/cdc_sync_fall.sv
// Multi-flop synchronizer for an active-low async strobe, with a one-cycle
// pulse on its synchronized falling edge. Flops idle high.
module cdc_sync_fall #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_n,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              last_q, last_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_n};
    last_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign fall_c = last_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: writes GB frames into one RAM, hands completed
// frames to the display on its vsync, dropping or repeating frames as needed.
module frame_buffer_scheduler (
  input  logic                     clk_in,
  input  logic                     rst,
  frame_buffer_scheduler_if.slave  bus
);
  import gb_video_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] MIN_ADDR  = ADDR_W'(MIN_PIXELS);

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              vsync_q, vsync_d;
  buf_idx_t          wr_buf_q, wr_buf_d;
  buf_idx_t          pend_buf_q, pend_buf_d;
  buf_idx_t          rd_buf_q, rd_buf_d;
  logic              fresh_q, fresh_d;
  cnt_t              drop_q, drop_d;
  cnt_t              rep_q, rep_d;

  logic vsync_edge_c;
  logic commit_c;
  logic take_c;

  cdc_sync_fall #(
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .async_n (bus.rd_vsync_n),
    .fall_c  (take_c)
  );

  // Writer FSM: a vsync edge always restarts the frame; the address saturates at the last pixel.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    vsync_d      = bus.gb_vsync;
    commit_c     = 1'b0;
    vsync_edge_c = bus.gb_vsync & ~vsync_q;
    if (vsync_edge_c) begin
      commit_c  = (state_q == W_FULL) || ((state_q == W_ACTIVE) && (wr_addr_q >= MIN_ADDR));
      state_d   = W_ACTIVE;
      wr_addr_d = '0;
    end else begin
      case (state_q)
        W_ACTIVE: begin
          if (bus.gb_de) begin
            if (wr_addr_q == LAST_ADDR) begin
              state_d = W_FULL;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer rotation: all three indices move together so they stay a permutation.
  always_comb begin
    wr_buf_d   = wr_buf_q;
    pend_buf_d = pend_buf_q;
    rd_buf_d   = rd_buf_q;
    fresh_d    = fresh_q;
    drop_d     = drop_q;
    rep_d      = rep_q;
    case ({commit_c, take_c})
      2'b11: begin
        wr_buf_d = rd_buf_q;
        rd_buf_d = wr_buf_q;
        fresh_d  = 1'b0;
        if (fresh_q) drop_d = sat_inc(drop_q);
      end
      2'b10: begin
        wr_buf_d   = pend_buf_q;
        pend_buf_d = wr_buf_q;
        fresh_d    = 1'b1;
        if (fresh_q) drop_d = sat_inc(drop_q);
      end
      2'b01: begin
        if (fresh_q) begin
          rd_buf_d   = pend_buf_q;
          pend_buf_d = rd_buf_q;
          fresh_d    = 1'b0;
        end else begin
          rep_d = sat_inc(rep_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= W_IDLE;
      wr_addr_q  <= '0;
      vsync_q    <= 1'b0;
      wr_buf_q   <= buf_idx_t'(0);
      pend_buf_q <= buf_idx_t'(2);
      rd_buf_q   <= buf_idx_t'(1);
      fresh_q    <= 1'b0;
      drop_q     <= '0;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      vsync_q    <= vsync_d;
      wr_buf_q   <= wr_buf_d;
      pend_buf_q <= pend_buf_d;
      rd_buf_q   <= rd_buf_d;
      fresh_q    <= fresh_d;
      drop_q     <= drop_d;
      rep_q      <= rep_d;
    end
  end

  assign bus.wr_en       = bus.gb_de && (state_q == W_ACTIVE);
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_buf      = wr_buf_q;
  assign bus.rd_buf      = rd_buf_q;
  assign bus.frame_fresh = fresh_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.repeat_cnt  = rep_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler: event-level model checked every
// cycle, plus hand-computed checkpoints along the scenario.
module tb_frame_buffer_scheduler;

  localparam int FRAME = 23040;
  localparam int MINP  = 11600;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  frame_buffer_scheduler_if bus ();

  frame_buffer_scheduler dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int wr_en_seen = 0;

  // Model state: frame progress as a pixel count, buffer roles as plain ints.
  int m_mode    = 0;  // 0 waiting for first vsync, 1 writing, 2 frame full
  int m_written = 0;
  int m_wr      = 0;
  int m_pend    = 2;
  int m_rd      = 1;
  int m_fresh   = 0;
  int m_drop    = 0;
  int m_rep     = 0;
  int m_prev_vs = 0;
  int m_h0 = 1, m_h1 = 1, m_h2 = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_written = 0;
    m_wr = 0; m_pend = 2; m_rd = 1;
    m_fresh = 0; m_drop = 0; m_rep = 0;
    m_prev_vs = 0; m_h0 = 1; m_h1 = 1; m_h2 = 1;
  endtask

  task automatic model_step();
    int  edge_s, take_s, commit_s, t;
    edge_s    = (bus.gb_vsync == 1'b1) && (m_prev_vs == 0);
    m_prev_vs = int'(bus.gb_vsync);
    // The display's fall is seen at this edge when the sample two edges ago was low and the one before was high.
    take_s = (m_h1 == 0) && (m_h2 == 1);
    m_h2 = m_h1; m_h1 = m_h0; m_h0 = int'(bus.rd_vsync_n);
    commit_s = 0;
    if (edge_s) begin
      commit_s  = (m_mode != 0) && (m_written >= MINP);
      m_mode    = 1;
      m_written = 0;
    end else if (m_mode == 1 && bus.gb_de) begin
      m_written++;
      if (m_written == FRAME) m_mode = 2;
    end
    if (commit_s && take_s) begin
      t = m_wr; m_wr = m_rd; m_rd = t;
      if (m_fresh == 1 && m_drop < 255) m_drop++;
      m_fresh = 0;
    end else if (commit_s) begin
      t = m_wr; m_wr = m_pend; m_pend = t;
      if (m_fresh == 1 && m_drop < 255) m_drop++;
      m_fresh = 1;
    end else if (take_s) begin
      if (m_fresh == 1) begin
        t = m_rd; m_rd = m_pend; m_pend = t;
        m_fresh = 0;
      end else if (m_rep < 255) begin
        m_rep++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    int exp_addr;
    @(negedge clk_in);
    exp_addr = (m_written >= FRAME) ? FRAME - 1 : m_written;
    if (bus.wr_en) wr_en_seen++;
    chk("wr_addr",     int'(bus.wr_addr),     exp_addr);
    chk("wr_en",       int'(bus.wr_en),       int'(bus.gb_de && m_mode == 1));
    chk("wr_buf",      int'(bus.wr_buf),      m_wr);
    chk("rd_buf",      int'(bus.rd_buf),      m_rd);
    chk("frame_fresh", int'(bus.frame_fresh), m_fresh);
    chk("drop_cnt",    int'(bus.drop_cnt),    m_drop);
    chk("repeat_cnt",  int'(bus.repeat_cnt),  m_rep);
    chk("perm", int'(bus.wr_buf != bus.rd_buf && bus.wr_buf < 2'd3 && bus.rd_buf < 2'd3), 1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic pixels(input int n);
    bus.gb_de = 1'b1;
    cyc(n);
    bus.gb_de = 1'b0;
  endtask

  task automatic vsync_pulse();
    bus.gb_vsync = 1'b1;
    cyc(1);
    bus.gb_vsync = 1'b0;
    cyc(1);
  endtask

  initial begin
    bus.gb_de      = 1'b0;
    bus.gb_vsync   = 1'b0;
    bus.rd_vsync_n = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    // 1: no vsync yet, pixels are ignored
    bus.gb_de = 1'b1;
    cyc(100);
    chk("t1_wr_en", int'(bus.wr_en), 0);
    bus.gb_de = 1'b0;
    chk("t1_wr_addr", int'(bus.wr_addr), 0);
    chk("t1_wr_buf",  int'(bus.wr_buf), 0);
    chk("t1_rd_buf",  int'(bus.rd_buf), 1);

    // 2: one complete frame
    vsync_pulse();
    pixels(FRAME);
    chk("t2_addr_end", int'(bus.wr_addr), FRAME - 1);
    vsync_pulse();
    chk("t2_wr_en_count", wr_en_seen, FRAME);
    chk("t2_wr_buf", int'(bus.wr_buf), 2);
    chk("t2_rd_buf", int'(bus.rd_buf), 1);
    chk("t2_fresh",  int'(bus.frame_fresh), 1);
    chk("t2_addr",   int'(bus.wr_addr), 0);

    // 3: display take, then a repeat
    bus.rd_vsync_n = 1'b0;
    cyc(2);
    chk("t3_rd_buf_hold", int'(bus.rd_buf), 1);
    cyc(1);
    chk("t3_rd_buf", int'(bus.rd_buf), 0);
    chk("t3_fresh",  int'(bus.frame_fresh), 0);
    bus.rd_vsync_n = 1'b1;
    cyc(4);
    bus.rd_vsync_n = 1'b0;
    cyc(4);
    bus.rd_vsync_n = 1'b1;
    cyc(4);
    chk("t3_repeat",  int'(bus.repeat_cnt), 1);
    chk("t3_rd_buf2", int'(bus.rd_buf), 0);

    // 4: two minimum-length commits with no take
    pixels(MINP);
    vsync_pulse();
    chk("t4_wr_buf_a", int'(bus.wr_buf), 1);
    chk("t4_fresh_a",  int'(bus.frame_fresh), 1);
    chk("t4_drop_a",   int'(bus.drop_cnt), 0);
    pixels(MINP);
    vsync_pulse();
    chk("t4_wr_buf_b", int'(bus.wr_buf), 2);
    chk("t4_rd_buf_b", int'(bus.rd_buf), 0);
    chk("t4_fresh_b",  int'(bus.frame_fresh), 1);
    chk("t4_drop_b",   int'(bus.drop_cnt), 1);

    // 5: short frame aborts, then an overlong frame saturates the address
    pixels(5000);
    vsync_pulse();
    chk("t5_wr_buf", int'(bus.wr_buf), 2);
    chk("t5_fresh",  int'(bus.frame_fresh), 1);
    chk("t5_addr",   int'(bus.wr_addr), 0);
    chk("t5_drop",   int'(bus.drop_cnt), 1);
    pixels(25000);
    bus.gb_de = 1'b1;
    #1;
    chk("t5_full_wr_en", int'(bus.wr_en), 0);
    bus.gb_de = 1'b0;
    chk("t5_full_addr", int'(bus.wr_addr), FRAME - 1);

    // 6: commit and take land on the same edge
    bus.rd_vsync_n = 1'b0;
    cyc(2);
    bus.gb_vsync = 1'b1;
    cyc(1);
    chk("t6_rd_buf", int'(bus.rd_buf), 2);
    chk("t6_wr_buf", int'(bus.wr_buf), 0);
    chk("t6_fresh",  int'(bus.frame_fresh), 0);
    chk("t6_drop",   int'(bus.drop_cnt), 2);
    chk("t6_repeat", int'(bus.repeat_cnt), 1);
    bus.gb_vsync   = 1'b0;
    bus.rd_vsync_n = 1'b1;
    pixels(50);
    chk("t6_addr_mid", int'(bus.wr_addr), 50);

    // 6b: asynchronous reset mid-frame, checked before any clock edge
    bus.gb_de = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_wr_en",   int'(bus.wr_en), 0);
    chk("rst_wr_buf",  int'(bus.wr_buf), 0);
    chk("rst_rd_buf",  int'(bus.rd_buf), 1);
    chk("rst_fresh",   int'(bus.frame_fresh), 0);
    chk("rst_drop",    int'(bus.drop_cnt), 0);
    chk("rst_repeat",  int'(bus.repeat_cnt), 0);
    bus.gb_de = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
